// File: rtl/ram_dp_sync.sv
// Simple dual-port synchronous RAM: one write port, one read port, single clock.
// Byte-lane writes, 1- or 2-cycle read latency, read-during-write policy and post-reset clear.
module ram_dp_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RAM_DEPTH  = 512,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_err,
  output logic                             init_done
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic                  RST_INIT  = (INIT_CLEAR == 0);

  typedef enum logic {S_CLEAR, S_READY} state_e;
  localparam state_e RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_READY;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  logic                  clr_we_c;
  logic                  wr_in_range_c, rd_in_range_c;
  logic                  wr_acc_c, rd_acc_c;
  logic [IDX_W-1:0]      wr_idx_c, rd_idx_c, clr_idx_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Address qualification; out-of-range indices are steered to 0 and never used.
  always_comb begin
    wr_in_range_c = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range_c = ({1'b0, rd_addr} < DEPTH_L);
    wr_acc_c      = init_done_q & wr_en & wr_in_range_c;
    rd_acc_c      = init_done_q & rd_en;
    wr_idx_c      = wr_in_range_c ? IDX_W'(wr_addr) : '0;
    rd_idx_c      = rd_in_range_c ? IDX_W'(rd_addr) : '0;
    clr_idx_c     = IDX_W'(clr_cnt_q);
    clr_we_c      = (state_q == S_CLEAR);
  end

  // Read word with optional write-first bypass of the enabled lanes.
  always_comb begin
    rd_word_c = mem[rd_idx_c];
    if (RDW_MODE == 1 && wr_acc_c && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Clear sequencer and first read stage.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    s1_valid_d  = 1'b0;
    s1_err_d    = s1_err_q;
    s1_data_d   = s1_data_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d     = S_READY;
          init_done_d = 1'b1;
          clr_cnt_d   = '0;
        end
      end
      default: ;
    endcase
    if (rd_acc_c) begin
      s1_valid_d = 1'b1;
      s1_err_d   = ~rd_in_range_c;
      s1_data_d  = rd_in_range_c ? rd_word_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= RST_INIT;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_data_q   <= s1_data_d;
    end
  end

  // Storage array; contents survive rst_n and are zeroed only by the clear sequencer.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_idx_c] <= '0;
    end else if (wr_acc_c) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) mem[wr_idx_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Extra output stage; holds its data when nothing completes.
      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_err_d   = s2_err_q;
        s2_data_d  = s2_data_q;
        if (s1_valid_q) begin
          s2_err_d  = s1_err_q;
          s2_data_d = s1_data_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign rd_data  = s2_data_q;
      assign rd_valid = s2_valid_q;
      assign rd_err   = s2_err_q;
    end else begin : g_lat1
      assign rd_data  = s1_data_q;
      assign rd_valid = s1_valid_q;
      assign rd_err   = s1_err_q;
    end
  endgenerate

  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: two configurations share one stimulus stream and are
// compared every cycle against an array-based reference model.
module tb_ram_dp_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [8:0]  rd_addr;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid, a_rd_err, b_rd_err, a_init_done, b_init_done;

  always #5 clk = ~clk;

  // A: full depth, latency 1, old-data.  B: depth 300, latency 2, write-first.
  ram_dp_sync #(.RAM_DEPTH(512), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_err(a_rd_err), .init_done(a_init_done));

  ram_dp_sync #(.RAM_DEPTH(300), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .init_done(b_init_done));

  int unsigned depth [2] = '{512, 300};
  int unsigned lat   [2] = '{1, 2};
  int unsigned rdw   [2] = '{0, 1};
  logic [31:0] mem [2][512];
  int unsigned clr_left [2];
  logic        pend_v [2];
  logic        pend_e [2];
  logic [31:0] pend_d [2];
  logic        exp_v [2];
  logic        exp_e [2];
  logic        exp_init [2];
  logic [31:0] exp_d [2];
  int n_asrt = 0;
  int n_fail = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = depth[k];
      pend_v[k]   = 1'b0;
      exp_v[k]    = 1'b0;
      exp_e[k]    = 1'b0;
      exp_d[k]    = '0;
      exp_init[k] = 1'b0;
    end
  endtask

  // One clock edge of each configuration, from the behavioural rules.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit ready, wr_ok, rv, re, ov, oe;
      logic [31:0] rdat, od;
      ready = (clr_left[k] == 0);
      wr_ok = ready && wr_en && (wr_addr < depth[k]);
      rv = 0; re = 0; rdat = '0;
      if (ready && rd_en) begin
        rv = 1;
        if (rd_addr >= depth[k]) re = 1;
        else begin
          rdat = mem[k][rd_addr];
          if (rdw[k] == 1 && wr_ok && wr_addr == rd_addr) rdat = merge(rdat, wr_data, wr_be);
        end
      end
      if (wr_ok) mem[k][wr_addr] = merge(mem[k][wr_addr], wr_data, wr_be);
      if (!ready) begin
        clr_left[k]--;
        if (clr_left[k] == 0) for (int i = 0; i < 512; i++) mem[k][i] = '0;
      end
      if (lat[k] == 1) begin
        ov = rv; oe = re; od = rdat;
      end else begin
        ov = pend_v[k]; oe = pend_e[k]; od = pend_d[k];
        pend_v[k] = rv; pend_e[k] = re; pend_d[k] = rdat;
      end
      exp_v[k] = ov;
      if (ov) begin
        exp_d[k] = od;
        exp_e[k] = oe;
      end
      exp_init[k] = (clr_left[k] == 0);
    end
  endtask

  task automatic compare_all();
    chk("a_rd_valid", 32'(a_rd_valid), 32'(exp_v[0]));
    chk("a_rd_data", a_rd_data, exp_d[0]);
    chk("a_init_done", 32'(a_init_done), 32'(exp_init[0]));
    if (exp_v[0]) chk("a_rd_err", 32'(a_rd_err), 32'(exp_e[0]));
    chk("b_rd_valid", 32'(b_rd_valid), 32'(exp_v[1]));
    chk("b_rd_data", b_rd_data, exp_d[1]);
    chk("b_init_done", 32'(b_init_done), 32'(exp_init[1]));
    if (exp_v[1]) chk("b_rd_err", 32'(b_rd_err), 32'(exp_e[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
  endtask

  task automatic rnd_inputs(input bit narrow);
    wr_en   = 1'($urandom_range(0, 1));
    rd_en   = 1'($urandom_range(0, 1));
    wr_be   = 4'($urandom);
    wr_data = $urandom;
    wr_addr = narrow ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
    rd_addr = narrow ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
  endtask

  task automatic do_wr(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
    idle();
    wr_en = 1; wr_addr = addr; wr_data = data; wr_be = be;
    step();
    idle();
  endtask

  // Read on one edge; A (latency 1) is sampled after it, B (latency 2) one cycle later.
  task automatic rd_check(input string tag, input logic [8:0] addr,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_en = 1; rd_addr = addr;
    step();
    idle();
    chk({tag, "_a_valid"}, 32'(a_rd_valid), 32'd1);
    chk({tag, "_a_data"}, a_rd_data, exp_a);
    step();
    chk({tag, "_b_valid"}, 32'(b_rd_valid), 32'd1);
    chk({tag, "_b_data"}, b_rd_data, exp_b);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_a_data", a_rd_data, 32'h0);
    chk("rst_a_init", 32'(a_init_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Clear in progress with traffic that must be ignored, then abort it at cycle 200.
    repeat (200) begin
      rnd_inputs(1'b0);
      step();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("midclr_b_valid", 32'(b_rd_valid), 32'd0);
    chk("midclr_a_init", 32'(a_init_done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Full restart of the clear; per-cycle checks pin init_done timing for both depths.
    repeat (511) begin
      rnd_inputs(1'b0);
      step();
    end
    chk("clr_511_a_init", 32'(a_init_done), 32'd0);
    idle();
    step();
    chk("clr_512_a_init", 32'(a_init_done), 32'd1);

    rd_check("rd100_zero", 9'd100, 32'h0, 32'h0);
    do_wr(9'd100, 32'h0000_0006, 4'hF);
    rd_check("rd100", 9'd100, 32'h0000_0006, 32'h0000_0006);

    do_wr(9'd5, 32'hAABB_CCDD, 4'hF);
    do_wr(9'd5, 32'h1122_3344, 4'b0101);
    rd_check("lanes", 9'd5, 32'hAA22_CC44, 32'hAA22_CC44);

    do_wr(9'd7, 32'h0000_0001, 4'hF);
    wr_en = 1; wr_addr = 9'd7; wr_data = 32'h0000_0002; wr_be = 4'hF;
    rd_check("rdw", 9'd7, 32'h0000_0001, 32'h0000_0002);

    do_wr(9'd400, 32'hDEAD_BEEF, 4'hF);
    rd_check("oor", 9'd400, 32'hDEAD_BEEF, 32'h0);
    chk("oor_b_err", 32'(b_rd_err), 32'd1);
    rd_check("alias144", 9'd144, 32'h0, 32'h0);

    // Random mix: narrow address window forces collisions, idle gaps exercise hold.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else rnd_inputs(($urandom_range(0, 1) == 1));
      step();
    end
    idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock. Adds byte-lane write enables, selectable read latency (1 or 2), a defined read-during-write policy, out-of-range address detection, and a post-reset clear engine that zeroes the array. It is the general-purpose storage primitive for buffers and FIFOs in the design.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, width of one byte lane
ADDR_WIDTH, 9, address width
RAM_DEPTH, 512, number of words; must satisfy RAM_DEPTH <= 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in clocks; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-first)
INIT_CLEAR, 1, 1 = zero the whole array after reset, 0 = no clear

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data, registered
rd_valid  out  1  one-cycle pulse; rd_data holds the result of one accepted read
rd_err  out  1  qualifies rd_valid; high when that read's address was >= RAM_DEPTH
init_done  out  1  high when the array is ready for access

Behaviour:
- Reset (rst_n low, asynchronous): rd_data=0, rd_valid=0, rd_err=0, all pipeline stages cleared, clear counter=0. init_done=0 if INIT_CLEAR=1, otherwise 1.
- Memory contents are not reset by rst_n. They are only zeroed by the clear engine.
- FSM states:
  - CLEAR: on each edge, writes 0 to mem[clr_cnt] and increments clr_cnt. After writing RAM_DEPTH-1, moves to READY.
  - READY: normal operation.
- Reset exit state is CLEAR when INIT_CLEAR=1, otherwise READY.
- CLEAR lasts exactly RAM_DEPTH cycles. init_done rises on the edge that writes the last address.
- In CLEAR, wr_en and rd_en are ignored: no write occurs, and rd_valid stays 0.
- Reset asserted mid-CLEAR aborts the clear. After release, the clear restarts from address 0.
- Write: a write is accepted on an edge when init_done, wr_en, and wr_addr < RAM_DEPTH are all true.
  - Only lanes with wr_be[i]=1 are updated.
  - wr_be=0 makes the write a no-op.
  - A write with wr_addr >= RAM_DEPTH is dropped silently.
- Read: a read is accepted on an edge when init_done and rd_en are both true.
  - RD_LATENCY=1: rd_data and rd_valid update on the accepting edge N, so they are visible in the cycle after N.
  - RD_LATENCY=2: the result passes through one extra register stage and appears at edge N+1.
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give back-to-back rd_valid, one read per clock of throughput.
- When no read completes, rd_data holds its last value and rd_valid=0.
- Out-of-range read: rd_data=0 and rd_err=1, both coincident with rd_valid.
- Read and write to the same in-range address on the same edge:
  - RDW_MODE=0: rd_data returns the pre-write word.
  - RDW_MODE=1: rd_data returns the merged word, i.e. lanes with wr_be set take wr_data and the other lanes keep the old data.
- Reads and writes to different addresses on the same edge are independent.
- Address arithmetic does not wrap. Any address >= RAM_DEPTH is out of range, including when RAM_DEPTH < 2**ADDR_WIDTH.

Test Plan:
1. Reset, INIT_CLEAR=1, RAM_DEPTH=512 -> init_done low for exactly 512 cycles, then high. A read of addr 100 returns 0 with rd_valid after RD_LATENCY cycles.
2. Write addr 100 = 0x00000006 with wr_be=4'hF. Read addr 100 at RD_LATENCY=1, then at RD_LATENCY=2 -> rd_data=0x00000006, with rd_valid exactly 1 and 2 cycles after the request edge respectively.
3. Addr 5 holds 0xAABBCCDD. Write 0x11223344 with wr_be=4'b0101 -> a read of addr 5 returns 0xAA22CC44.
4. Addr 7 holds 0x0000_0001. On the same edge, write 0x0000_0002 to addr 7 and read addr 7 -> RDW_MODE=0 returns 0x00000001; RDW_MODE=1 returns 0x00000002.
5. RAM_DEPTH=300, ADDR_WIDTH=9. Write addr 400, then read addr 400 -> rd_data=0, rd_err=1, rd_valid=1. Addr 144 (400 mod 256) is unchanged.
6. Assert rst_n low at clear cycle 200, hold 3 cycles, release -> init_done stays 0 for a full 512 cycles after release. Reads and writes issued before init_done produce no rd_valid and leave memory at 0.
